// File: rtl/fa_pkg.sv
// fa_pkg -- shared definitions for the full_adder_triple cell.
//
// Holds the 1-bit full-adder truth table, indexed by {ci,a,b} and returning
// {s,co}. The case-style cell and any golden model read the same constant,
// so both sides agree on one table.
package fa_pkg;

    // Entry k holds {s,co} for {ci,a,b} == k. The concatenation lists entry 7 first.
    localparam logic [7:0][1:0] FA_TT = {
        2'b11,  // 111
        2'b01,  // 110
        2'b01,  // 101
        2'b10,  // 100
        2'b01,  // 011
        2'b10,  // 010
        2'b10,  // 001
        2'b00   // 000
    };

    function automatic logic [1:0] fa_lookup(input logic ci, input logic a, input logic b);
        return FA_TT[{ci, a, b}];
    endfunction

endpackage

// File: rtl/fa_cell_case.sv
// fa_cell_case -- 1-bit full adder written as an explicit truth-table case.
//
// Ports:
//   a, b, ci : operand bits and carry in
//   s, co    : sum and carry out (combinational)
//
// Any X/Z on the inputs falls to the default arm and yields 0 on both outputs.
module fa_cell_case
    import fa_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic [1:0] sc;

    always_comb begin
        sc = 2'b00;
        case ({ci, a, b})
            3'b000:  sc = FA_TT[0];
            3'b001:  sc = FA_TT[1];
            3'b010:  sc = FA_TT[2];
            3'b011:  sc = FA_TT[3];
            3'b100:  sc = FA_TT[4];
            3'b101:  sc = FA_TT[5];
            3'b110:  sc = FA_TT[6];
            3'b111:  sc = FA_TT[7];
            default: sc = 2'b00;
        endcase
    end

    assign s  = sc[1];
    assign co = sc[0];

endmodule

// File: rtl/full_adder_triple.sv
// full_adder_triple -- registered WIDTH-bit ripple adder built three ways
// (dataflow equations, arithmetic add, truth-table case) with all three
// results registered for cross-checking.
//
// Ports:
//   clk, rst_n        : clock; asynchronous active-low reset (clears all outputs)
//   a, b, ci          : operands and carry in, sampled every rising edge
//   s_df, co_df       : dataflow-style sum / carry out (1-cycle latency)
//   s_bh, co_bh       : behavioural-style sum / carry out
//   s_cs, co_cs       : case-style sum / carry out
//   mismatch          : registered disagreement flag between the three styles
//
// Build option: define FA_MISMATCH_CHECK_EN to enable the compare logic
// behind mismatch; otherwise mismatch is tied to 0.
module full_adder_triple
    import fa_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] s_df,
    output logic             co_df,
    output logic [WIDTH-1:0] s_bh,
    output logic             co_bh,
    output logic [WIDTH-1:0] s_cs,
    output logic             co_cs,
    output logic             mismatch
);

    // ---------------- dataflow style: per-bit equations, chained carry
    logic [WIDTH-1:0] sum_df;
    logic [WIDTH:0]   carry_df;

    assign carry_df[0] = ci;

    for (genvar i = 0; i < WIDTH; i++) begin : g_df
        assign sum_df[i]     = a[i] ^ b[i] ^ carry_df[i];
        assign carry_df[i+1] = (a[i] & b[i]) | (a[i] & carry_df[i]) | (b[i] & carry_df[i]);
    end

    // ---------------- behavioural style: one add, one bit wider so the carry survives
    logic [WIDTH:0] total_bh;

    assign total_bh = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};

    // ---------------- case style: array of truth-table cells, chained carry
    logic [WIDTH-1:0] sum_cs;
    logic [WIDTH:0]   carry_cs;

    assign carry_cs[0] = ci;

    fa_cell_case u_cell [WIDTH-1:0] (
        .a  (a),
        .b  (b),
        .ci (carry_cs[WIDTH-1:0]),
        .s  (sum_cs),
        .co (carry_cs[WIDTH:1])
    );

    // ---------------- output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_df  <= '0;
            co_df <= 1'b0;
            s_bh  <= '0;
            co_bh <= 1'b0;
            s_cs  <= '0;
            co_cs <= 1'b0;
        end else begin
            s_df  <= sum_df;
            co_df <= carry_df[WIDTH];
            s_bh  <= total_bh[WIDTH-1:0];
            co_bh <= total_bh[WIDTH];
            s_cs  <= sum_cs;
            co_cs <= carry_cs[WIDTH];
        end
    end

`ifdef FA_MISMATCH_CHECK_EN
    // Compare the combinational results so the flag lines up with the
    // registered sums it describes.
    logic mismatch_next;

    always_comb begin
        mismatch_next = 1'b0;
        if (({carry_df[WIDTH], sum_df} != total_bh) ||
            ({carry_cs[WIDTH], sum_cs} != total_bh))
            mismatch_next = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mismatch <= 1'b0;
        else        mismatch <= mismatch_next;
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_full_adder_triple.sv
// Scoreboard bench for full_adder_triple: three instances (WIDTH 1, 4, 8)
// share one stimulus stream (narrow ones see the low bits). The driver
// pushes expected results on each issued vector; the monitor pops and
// compares one cycle later.
module tb_full_adder_triple;
    import fa_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic [7:0] a8, b8;
    logic ci;

    always #5 clk = ~clk;

    logic [0:0] s1_df, s1_bh, s1_cs;
    logic [3:0] s4_df, s4_bh, s4_cs;
    logic [7:0] s8_df, s8_bh, s8_cs;
    logic co1_df, co1_bh, co1_cs, mm1;
    logic co4_df, co4_bh, co4_cs, mm4;
    logic co8_df, co8_bh, co8_cs, mm8;

    full_adder_triple #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .a(a8[0:0]), .b(b8[0:0]), .ci(ci),
        .s_df(s1_df), .co_df(co1_df), .s_bh(s1_bh), .co_bh(co1_bh),
        .s_cs(s1_cs), .co_cs(co1_cs), .mismatch(mm1));

    full_adder_triple #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .a(a8[3:0]), .b(b8[3:0]), .ci(ci),
        .s_df(s4_df), .co_df(co4_df), .s_bh(s4_bh), .co_bh(co4_bh),
        .s_cs(s4_cs), .co_cs(co4_cs), .mismatch(mm4));

    full_adder_triple #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .ci(ci),
        .s_df(s8_df), .co_df(co8_df), .s_bh(s8_bh), .co_bh(co8_bh),
        .s_cs(s8_cs), .co_cs(co8_cs), .mismatch(mm8));

    typedef struct {
        logic [1:0] r1;   // {co,s} for WIDTH=1
        logic [4:0] r4;   // {co,s} for WIDTH=4
        logic [8:0] r8;   // {co,s} for WIDTH=8
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-serial ripple through the shared truth table.
    function automatic logic [8:0] ripple(input int w, input logic [7:0] a, input logic [7:0] b,
                                          input logic c_in);
        logic [8:0] r;
        logic [1:0] sc;
        logic c;
        r = '0;
        c = c_in;
        for (int i = 0; i < w; i++) begin
            sc   = fa_lookup(c, a[i], b[i]);
            r[i] = sc[1];
            c    = sc[0];
        end
        r[w] = c;
        return r;
    endfunction

    task automatic issue(input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input logic [8:0] exp8);
        exp_t e;
        logic [8:0] t;
        @(negedge clk);
        a8 = av; b8 = bv; ci = cv;
        t    = ripple(1, av, bv, cv);
        e.r1 = t[1:0];
        t    = ripple(4, av, bv, cv);
        e.r4 = t[4:0];
        e.r8 = exp8;
        q.push_back(e);
    endtask

    // Monitor: outputs are valid every cycle one edge after issue.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && q.size() > 0) begin
            e = q.pop_front();
            check("w1_df", {7'd0, co1_df, s1_df}, {7'd0, e.r1});
            check("w1_bh", {7'd0, co1_bh, s1_bh}, {7'd0, e.r1});
            check("w1_cs", {7'd0, co1_cs, s1_cs}, {7'd0, e.r1});
            check("w4_df", {4'd0, co4_df, s4_df}, {4'd0, e.r4});
            check("w4_bh", {4'd0, co4_bh, s4_bh}, {4'd0, e.r4});
            check("w4_cs", {4'd0, co4_cs, s4_cs}, {4'd0, e.r4});
            check("w8_df", {co8_df, s8_df}, e.r8);
            check("w8_bh", {co8_bh, s8_bh}, e.r8);
            check("w8_cs", {co8_cs, s8_cs}, e.r8);
            check("mismatch", {6'd0, mm1, mm4, mm8}, 9'd0);
        end
    end

    // Directed vectors: a, b, ci and hand-computed 9-bit {co,s}.
    typedef struct { logic [7:0] a; logic [7:0] b; logic c; logic [8:0] r; } vec_t;
    vec_t vecs[$] = '{
        '{8'h00, 8'h00, 1'b0, 9'h000},   // {ci,a,b}=000
        '{8'h00, 8'h01, 1'b0, 9'h001},   // 001
        '{8'h01, 8'h00, 1'b0, 9'h001},   // 010
        '{8'h01, 8'h01, 1'b0, 9'h002},   // 011 -> s=0 co=1 at WIDTH=1
        '{8'h00, 8'h00, 1'b1, 9'h001},   // 100
        '{8'h00, 8'h01, 1'b1, 9'h002},   // 101
        '{8'h01, 8'h00, 1'b1, 9'h002},   // 110
        '{8'h01, 8'h01, 1'b1, 9'h003},   // 111 -> s=1 co=1 at WIDTH=1
        '{8'h0F, 8'h00, 1'b1, 9'h010},   // 4-bit wrap to 0 with carry
        '{8'h07, 8'h08, 1'b0, 9'h00F},   // 4-bit F, no carry
        '{8'hFF, 8'h00, 1'b1, 9'h100},
        '{8'h80, 8'h80, 1'b0, 9'h100},
        '{8'h55, 8'hAA, 1'b0, 9'h0FF},
        '{8'h12, 8'h34, 1'b1, 9'h047},
        '{8'hFF, 8'hFF, 1'b1, 9'h1FF}
    };

    initial begin
        logic [7:0] ra, rb;
        logic rc;
        // Reset asserted with all-ones inputs: outputs must be 0 before any edge.
        rst_n = 1'b0;
        a8 = 8'hFF; b8 = 8'hFF; ci = 1'b1;
        #3;
        check("rst_w8", {co8_df, s8_df} | {co8_bh, s8_bh} | {co8_cs, s8_cs}, 9'd0);
        check("rst_w1", {5'd0, co1_df, s1_df, co1_cs, s1_cs}, 9'd0);
        check("rst_mm", {6'd0, mm1, mm4, mm8}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) issue(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].r);

        // Mid-run reset: wait until the last result is showing, then clear.
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("midrst_w8", {co8_df, s8_df} | {co8_bh, s8_bh} | {co8_cs, s8_cs}, 9'd0);
        check("midrst_w4", {4'd0, co4_df, s4_df}, 9'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: 000 then 101; output must still be 00 until the second edge.
        issue(8'h00, 8'h00, 1'b0, 9'h000);
        issue(8'h00, 8'h01, 1'b1, 9'h002);
        #1;
        check("latency_hold", {7'd0, co1_df, s1_df}, 9'd0);

        // Back-to-back random traffic.
        for (int n = 0; n < 1000; n++) begin
            ra = 8'($urandom_range(255));
            rb = 8'($urandom_range(255));
            rc = 1'($urandom_range(1));
            issue(ra, rb, rc, {1'b0, ra} + {1'b0, rb} + {8'd0, rc});
        end

        @(posedge clk); #2;
        check("queue_drained", 9'(q.size()), 9'd0);

`ifdef FA_MISMATCH_CHECK_EN
        // Corrupt the dataflow sum for one cycle; only that cycle flags.
        @(negedge clk);
        a8 = 8'h12; b8 = 8'h34; ci = 1'b0;
        force u8.sum_df = 8'h47;
        @(posedge clk); #1;
        check("mm_forced", {8'd0, mm8}, 9'd1);
        @(negedge clk);
        release u8.sum_df;
        @(posedge clk); #1;
        check("mm_cleared", {8'd0, mm8}, 9'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
